// File: rtl/dpi_cmd_queue.sv
// Consumer stage for DPI host calls: serializes commands, computes CALC responses
// and queues PRINT snapshots of the stored value in a show-ahead FIFO.
module dpi_cmd_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     host_valid,
  input  logic [1:0]               host_op,
  input  logic [DATA_W-1:0]        host_data,
  output logic                     host_ready,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  output logic [DATA_W-1:0]        value,
  output logic                     print_valid,
  output logic [DATA_W-1:0]        print_data,
  input  logic                     print_ready,
  output logic [CNT_W-1:0]         print_count,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_CALC  = 2'd1;
  localparam logic [1:0] OP_PRINT = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  logic [DATA_W-1:0] value_q, value_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic ready_c;
  logic accept_c;
  logic push_c;
  logic pop_c;

  // Readiness depends only on registered occupancy, so a same-cycle pop never frees a slot early.
  always_comb begin
    ready_c  = (level_q != LVL_W'(DEPTH));
    accept_c = host_valid && ready_c;
    push_c   = accept_c && (host_op == OP_PRINT);
    pop_c    = (level_q != '0) && print_ready;
  end

  // Command execution and response pipeline.
  always_comb begin
    value_d     = value_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    if (accept_c) begin
      unique case (host_op)
        OP_CALC: begin
          value_d     = host_data + DATA_W'(1);
          rsp_valid_d = 1'b1;
          rsp_data_d  = host_data + DATA_W'(4);
        end
        OP_CLEAR: value_d = '0;
        OP_NOP, OP_PRINT: ;
        default: ;
      endcase
    end
  end

  // FIFO pointer, occupancy and completion-count update; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    count_d  = count_q;
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d  = count_q + CNT_W'(1);
    end
    unique case ({push_c, pop_c})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      count_q     <= '0;
    end else begin
      value_q     <= value_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && push_c) begin
      mem_q[wr_ptr_q] <= value_q;
    end
  end

  assign host_ready  = ready_c;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign value       = value_q;
  assign print_valid = (level_q != '0);
  assign print_data  = mem_q[rd_ptr_q];
  assign print_count = count_q;
  assign fifo_level  = level_q;

endmodule
